alu_seq: RTL

Registered, handshaked ALU for the datapath, parametrised in width. It generalises the combinational ALU into a pipeline stage with valid/ready flow control. It also adds an iterative multi-cycle unsigned multiply, saturating shift semantics, modulo rotates and correct subtract overflow. Results and flags are held in an output register until the consumer accepts them.

---
 rtl/alu_seq.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU pipeline stage with valid/ready flow control.
// Single-cycle ops complete on the accepting edge. MUL is an iterative
// shift-add that takes WIDTH cycles. The result and flags sit in an output
// register until the consumer takes them.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    // Shift-amount width, derived from WIDTH.
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_ASR = 4'b0110;
    localparam logic [3:0] OP_LSR = 4'b0111;
    localparam logic [3:0] OP_LSL = 4'b1000;
    localparam logic [3:0] OP_ROL = 4'b1010;
    localparam logic [3:0] OP_ROR = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1100;

    localparam logic [WIDTH:0]   W_EXT   = (WIDTH+1)'(WIDTH);
    localparam logic [WIDTH-1:0] W_B     = WIDTH'(WIDTH);
    localparam logic [SHW:0]     W_SH    = (SHW+1)'(WIDTH);
    localparam logic [SHW-1:0]   CNT_MAX = SHW'(WIDTH-1);

    // Handshake: a request transfers on a rising edge where in_valid && in_ready.
    // A result transfers on a rising edge where out_valid && out_ready. Neither
    // side queues anything. valid must not depend on ready.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;
    logic   accept;

    // Multiply datapath.
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [SHW-1:0]     cnt;
    logic               mul_last;
    logic               mul_hi;
    logic [3:0]         mul_flags;

    // Single-cycle ALU.
    logic [WIDTH:0]        sum;
    logic [WIDTH:0]        diff;
    logic [WIDTH:0]        shr_w;
    logic signed [WIDTH:0] asr_w;
    logic [2*WIDTH-1:0]    shl_w;
    logic [SHW-1:0]        sh;
    logic [SHW-1:0]        rot;
    logic [SHW:0]          rot_inv;
    logic                  big;
    logic [WIDTH-1:0]      alu_res;
    logic                  alu_c;
    logic                  alu_v;
    logic [3:0]            alu_flags;

    // Combinational ALU for every non-multiply opcode (unknown codes act as ADD).
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        big     = ({1'b0, b} >= W_EXT);
        sh      = b[SHW-1:0];
        rot     = SHW'(b % W_B);
        rot_inv = W_SH - {1'b0, rot};
        shr_w   = {a, 1'b0} >> sh;
        asr_w   = $signed({a, 1'b0}) >>> sh;
        shl_w   = {{WIDTH{1'b0}}, a} << sh;
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        case (func)
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: begin alu_res = a & b; alu_c = 1'b0; alu_v = 1'b0; end
            OP_OR:  begin alu_res = a | b; alu_c = 1'b0; alu_v = 1'b0; end
            OP_XOR: begin alu_res = a ^ b; alu_c = 1'b0; alu_v = 1'b0; end
            OP_NOT: begin alu_res = ~a;    alu_c = 1'b0; alu_v = 1'b0; end
            OP_ASR: begin
                alu_v = 1'b0;
                if (big) begin
                    alu_res = {WIDTH{a[WIDTH-1]}};
                    alu_c   = a[WIDTH-1];
                end else begin
                    alu_res = asr_w[WIDTH:1];
                    alu_c   = asr_w[0];
                end
            end
            OP_LSR: begin
                alu_v = 1'b0;
                if (big) begin
                    alu_res = '0;
                    alu_c   = 1'b0;
                end else begin
                    alu_res = shr_w[WIDTH:1];
                    alu_c   = shr_w[0];
                end
            end
            OP_LSL: begin
                if (big) begin
                    alu_res = '0;
                    alu_c   = 1'b0;
                    alu_v   = |a;
                end else begin
                    alu_res = shl_w[WIDTH-1:0];
                    alu_c   = shl_w[WIDTH];
                    alu_v   = (|shl_w[2*WIDTH-1:WIDTH]) || (shl_w[WIDTH-1] != a[WIDTH-1]);
                end
            end
            OP_ROL: begin
                alu_res = (a << rot) | (a >> rot_inv);
                alu_c   = (rot != '0) && alu_res[0];
                alu_v   = 1'b0;
            end
            OP_ROR: begin
                alu_res = (a >> rot) | (a << rot_inv);
                alu_c   = (rot != '0) && alu_res[WIDTH-1];
                alu_v   = 1'b0;
            end
            default: ;
        endcase
        alu_flags = {alu_c, (alu_res == '0), alu_v, alu_res[WIDTH-1]};
    end

    // One partial product per BUSY cycle; the multiplier is consumed LSB first.
    always_comb begin
        acc_next  = acc + (mplier[0] ? mcand : '0);
        mul_last  = (cnt == CNT_MAX);
        mul_hi    = |acc_next[2*WIDTH-1:WIDTH];
        mul_flags = {mul_hi, (acc_next[WIDTH-1:0] == '0), mul_hi, acc_next[WIDTH-1]};
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_IDLE: in_ready = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
        accept = in_valid && in_ready;
        if (accept)                             state_next = (func == OP_MUL) ? S_BUSY : S_DONE;
        else if (state == S_DONE && out_ready)  state_next = S_IDLE;
        else if (state == S_BUSY && mul_last)   state_next = S_DONE;
    end

    // Output register and multiply iteration state.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            flags  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept) begin
            if (func == OP_MUL) begin
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                acc    <= '0;
                cnt    <= '0;
            end else begin
                result <= alu_res;
                flags  <= alu_flags;
            end
        end else if (state == S_BUSY) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + SHW'(1);
            if (mul_last) begin
                result <= acc_next[WIDTH-1:0];
                flags  <= mul_flags;
            end
        end
    end

endmodule
